// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//    Bundle of the arbiter's memory bus signals: the packed request side of
//    NUM_MASTERS masters and the single shared slave port.
//    Modports:
//       master : view taken by the arbiter, which masters the shared slave
//                port (drives s_*, m_ack, m_data_in).
//       slave  : view taken by the surroundings (requesting masters plus the
//                memory), which drive m_* requests and s_ack / s_data_in.
//    Master i occupies slice i of every packed m_* vector.
interface mem_bus_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 19,
   parameter int DATA_WIDTH  = 16
);
   localparam int BW = DATA_WIDTH / 8;

   // Requesting-master side
   logic [NUM_MASTERS-1:0]            m_access;
   logic [NUM_MASTERS-1:0]            m_lock;
   logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out;
   logic [NUM_MASTERS-1:0]            m_wr_en;
   logic [NUM_MASTERS*BW-1:0]         m_bytesel;
   logic [NUM_MASTERS-1:0]            m_io;
   logic [NUM_MASTERS-1:0]            m_ack;
   logic [DATA_WIDTH-1:0]             m_data_in;

   // Shared slave side; word address, bit 0 is implied
   logic [ADDR_WIDTH:1]               s_addr;
   logic [DATA_WIDTH-1:0]             s_data_out;
   logic                              s_access;
   logic                              s_ack;
   logic [DATA_WIDTH-1:0]             s_data_in;
   logic                              s_wr_en;
   logic [BW-1:0]                     s_bytesel;
   logic                              s_io;

   modport master (
      input  m_access, m_lock, m_addr, m_data_out, m_wr_en, m_bytesel, m_io,
      input  s_ack, s_data_in,
      output m_ack, m_data_in,
      output s_addr, s_data_out, s_access, s_wr_en, s_bytesel, s_io
   );

   modport slave (
      output m_access, m_lock, m_addr, m_data_out, m_wr_en, m_bytesel, m_io,
      output s_ack, s_data_in,
      input  m_ack, m_data_in,
      input  s_addr, s_data_out, s_access, s_wr_en, s_bytesel, s_io
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//    N-master to 1-slave arbiter for the word-addressed access/ack memory bus.
//    Round-robin or fixed priority, plus a per-master lock that keeps the
//    grant across back-to-back transfers (indivisible read-modify-write).
//    Ports:
//       clk         : clock
//       reset       : synchronous, active-high reset
//       bus         : mem_bus_arbiter_if.master (all m_* and s_* signals)
//       grant_valid : a master currently owns the bus
//       grant_id    : index of the owning master
module mem_bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 19,
   parameter int DATA_WIDTH  = 16,
   parameter int ROUND_ROBIN = 1,
   localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   mem_bus_arbiter_if.master  bus,
   output logic               grant_valid,
   output logic [IDW-1:0]     grant_id
);
   localparam int BW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;

   state_t                state_reg;
   logic                  grant_valid_reg;
   logic [IDW-1:0]        grant_id_reg;
   logic [IDW-1:0]        ptr_reg;
   logic [IDW-1:0]        ptr_next;
   logic [IDW-1:0]        win_id;
   logic                  win_found;

   // Unpacked per-master views of the packed request fields
   logic [ADDR_WIDTH-1:0] addr_arr [NUM_MASTERS];
   logic [DATA_WIDTH-1:0] data_arr [NUM_MASTERS];
   logic [BW-1:0]         bsel_arr [NUM_MASTERS];

   // Fields of the currently granted master
   logic                  g_access;
   logic                  g_lock;
   logic                  g_wr_en;
   logic                  g_io;
   logic [ADDR_WIDTH-1:0] g_addr;
   logic [DATA_WIDTH-1:0] g_data;
   logic [BW-1:0]         g_bsel;
   logic                  busy;

   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
         assign addr_arr[gi] = bus.m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign data_arr[gi] = bus.m_data_out[gi*DATA_WIDTH +: DATA_WIDTH];
         assign bsel_arr[gi] = bus.m_bytesel[gi*BW +: BW];
      end
   endgenerate

   // Winner: first requester scanning upward from the pointer with wrap.
   // In fixed-priority mode the pointer never leaves 0, so this reduces to
   // lowest index wins.
   always_comb begin
      int idx;
      win_id    = '0;
      win_found = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = int'(ptr_reg) + k;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!win_found && (i == idx) && bus.m_access[i]) begin
               win_found = 1'b1;
               win_id    = IDW'(i);
            end
         end
      end
   end

   // Request mux for the granted master
   always_comb begin
      g_access = 1'b0;
      g_lock   = 1'b0;
      g_wr_en  = 1'b0;
      g_io     = 1'b0;
      g_addr   = '0;
      g_data   = '0;
      g_bsel   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_id_reg == IDW'(i)) begin
            g_access = bus.m_access[i];
            g_lock   = bus.m_lock[i];
            g_wr_en  = bus.m_wr_en[i];
            g_io     = bus.m_io[i];
            g_addr   = addr_arr[i];
            g_data   = data_arr[i];
            g_bsel   = bsel_arr[i];
         end
      end
   end

   assign ptr_next = (grant_id_reg == IDW'(NUM_MASTERS - 1)) ? '0
                                                             : grant_id_reg + IDW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         grant_valid_reg <= 1'b0;
         grant_id_reg    <= '0;
         ptr_reg         <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_found) begin
                  grant_id_reg    <= win_id;
                  grant_valid_reg <= 1'b1;
                  state_reg       <= BUSY;
               end
            end
            BUSY: begin
               if (bus.s_ack) begin
                  if (ROUND_ROBIN != 0) ptr_reg <= ptr_next;
                  if (g_lock) begin
                     state_reg <= LOCKED;
                  end else begin
                     state_reg       <= IDLE;
                     grant_valid_reg <= 1'b0;
                  end
               end else if (!g_access) begin
                  // Master withdrew its request before the ack: abandon the
                  // transfer silently.
                  state_reg       <= IDLE;
                  grant_valid_reg <= 1'b0;
               end
            end
            LOCKED: begin
               if (g_access) begin
                  state_reg <= BUSY;
               end else if (!g_lock) begin
                  state_reg       <= IDLE;
                  grant_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg       <= IDLE;
               grant_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   // Slave outputs are live only in BUSY. Gating with reset drops an ack
   // arriving in the same cycle as reset so no master sees a completion.
   always_comb begin
      busy           = (state_reg == BUSY) && !reset;
      bus.s_access   = busy && g_access;
      bus.s_addr     = busy ? g_addr : '0;
      bus.s_data_out = busy ? g_data : '0;
      bus.s_wr_en    = busy && g_wr_en;
      bus.s_bytesel  = busy ? g_bsel : '0;
      bus.s_io       = busy && g_io;
      bus.m_ack      = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         bus.m_ack[i] = busy && bus.s_ack && (grant_id_reg == IDW'(i));
      end
   end

   assign bus.m_data_in = bus.s_data_in;
   assign grant_valid   = grant_valid_reg;
   assign grant_id      = (NUM_MASTERS == 1) ? '0 : grant_id_reg;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//    Directed bench for mem_bus_arbiter. Three instances share clk/reset:
//       dut2 : 2 masters, round-robin (single master, write, lock, reset)
//       dut4 : 4 masters, round-robin (fairness)
//       dutf : 4 masters, fixed priority
//    Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   mem_bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(19), .DATA_WIDTH(16)) b2 ();
   mem_bus_arbiter_if #(.NUM_MASTERS(4), .ADDR_WIDTH(19), .DATA_WIDTH(16)) b4 ();
   mem_bus_arbiter_if #(.NUM_MASTERS(4), .ADDR_WIDTH(19), .DATA_WIDTH(16)) bf ();

   logic       gv2, gv4, gvf;
   logic       gid2;
   logic [1:0] gid4, gidf;

   mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(19), .DATA_WIDTH(16), .ROUND_ROBIN(1)) dut2 (
      .clk(clk), .reset(rst), .bus(b2.master), .grant_valid(gv2), .grant_id(gid2));
   mem_bus_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(19), .DATA_WIDTH(16), .ROUND_ROBIN(1)) dut4 (
      .clk(clk), .reset(rst), .bus(b4.master), .grant_valid(gv4), .grant_id(gid4));
   mem_bus_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(19), .DATA_WIDTH(16), .ROUND_ROBIN(0)) dutf (
      .clk(clk), .reset(rst), .bus(bf.master), .grant_valid(gvf), .grant_id(gidf));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   int exp_rr [5] = '{0, 1, 2, 3, 0};
   int ack_cnt [4];

   initial begin
      b2.m_access = '0; b2.m_lock = '0; b2.m_addr = '0; b2.m_data_out = '0;
      b2.m_wr_en = '0; b2.m_bytesel = '0; b2.m_io = '0; b2.s_ack = 1'b0; b2.s_data_in = '0;
      b4.m_access = '0; b4.m_lock = '0; b4.m_addr = '0; b4.m_data_out = '0;
      b4.m_wr_en = '0; b4.m_bytesel = '0; b4.m_io = '0; b4.s_ack = 1'b0; b4.s_data_in = '0;
      bf.m_access = '0; bf.m_lock = '0; bf.m_addr = '0; bf.m_data_out = '0;
      bf.m_wr_en = '0; bf.m_bytesel = '0; bf.m_io = '0; bf.s_ack = 1'b0; bf.s_data_in = '0;
      for (int i = 0; i < 4; i++) ack_cnt[i] = 0;

      // ---------------- reset state ----------------
      settle(); settle();
      settle(); rst = 1'b0; #1;
      check_val("rst_grant_valid", gv2, 0);
      check_val("rst_grant_id", gid2, 0);
      check_val("rst_s_access", b2.s_access, 0);
      check_val("rst_m_ack", b2.m_ack, 0);
      check_val("rst_s_addr", b2.s_addr, 0);

      // ---------------- single master read ----------------
      settle();
      b2.m_access[1] = 1'b1;
      b2.m_addr[19 +: 19] = 19'h12345;
      b2.m_bytesel[3:2] = 2'b11;
      #1;
      check_val("rd_arb_cycle_s_access", b2.s_access, 0);
      settle(); #1;
      check_val("rd_s_access", b2.s_access, 1);
      check_val("rd_s_addr", b2.s_addr, 32'h12345);
      check_val("rd_s_bytesel", b2.s_bytesel, 2'b11);
      check_val("rd_grant_id", gid2, 1);
      check_val("rd_grant_valid", gv2, 1);
      check_val("rd_m_ack_wait", b2.m_ack, 0);
      settle();
      settle(); b2.s_ack = 1'b1; b2.s_data_in = 16'hBEEF; #1;
      check_val("rd_m_ack", b2.m_ack, 2'b10);
      check_val("rd_m_data_in", b2.m_data_in, 16'hBEEF);
      settle(); b2.s_ack = 1'b0; b2.m_access[1] = 1'b0; #1;
      check_val("rd_done_grant_valid", gv2, 0);
      check_val("rd_done_s_access", b2.s_access, 0);

      // ---------------- write path (io, byte 1) ----------------
      settle();
      b2.m_access[0] = 1'b1; b2.m_wr_en[0] = 1'b1; b2.m_io[0] = 1'b1;
      b2.m_addr[0 +: 19] = 19'h00040;
      b2.m_data_out[0 +: 16] = 16'hA500;
      b2.m_bytesel[1:0] = 2'b10;
      for (int c = 0; c < 2; c++) begin
         settle();
         if (c == 1) b2.s_ack = 1'b1;
         #1;
         check_val("wr_s_wr_en", b2.s_wr_en, 1);
         check_val("wr_s_io", b2.s_io, 1);
         check_val("wr_s_bytesel", b2.s_bytesel, 2'b10);
         check_val("wr_s_data_out", b2.s_data_out, 16'hA500);
         check_val("wr_s_addr", b2.s_addr, 32'h40);
      end
      check_val("wr_m_ack", b2.m_ack, 2'b01);
      settle();
      b2.s_ack = 1'b0; b2.m_access[0] = 1'b0; b2.m_wr_en[0] = 1'b0; b2.m_io[0] = 1'b0;
      #1;
      check_val("wr_idle_s_wr_en", b2.s_wr_en, 0);
      check_val("wr_idle_s_data_out", b2.s_data_out, 0);

      // ---------------- lock: read then write by master 1 ----------------
      settle();
      b2.m_access[1] = 1'b1; b2.m_lock[1] = 1'b1; b2.m_addr[19 +: 19] = 19'h00010;
      settle();
      b2.m_access[0] = 1'b1; b2.m_addr[0 +: 19] = 19'h00777;
      b2.s_ack = 1'b1; b2.s_data_in = 16'h55AA; #1;
      check_val("lk_rd_grant_id", gid2, 1);
      check_val("lk_rd_s_addr", b2.s_addr, 32'h10);
      check_val("lk_rd_m_ack", b2.m_ack, 2'b10);
      settle(); b2.s_ack = 1'b0; b2.m_access[1] = 1'b0; #1;
      check_val("lk_hold_grant_valid", gv2, 1);
      check_val("lk_hold_grant_id", gid2, 1);
      check_val("lk_hold_s_access", b2.s_access, 0);
      check_val("lk_hold_s_addr", b2.s_addr, 0);
      settle();
      b2.m_access[1] = 1'b1; b2.m_wr_en[1] = 1'b1; b2.m_data_out[16 +: 16] = 16'h1234; #1;
      check_val("lk_reassert_s_access", b2.s_access, 0);
      settle(); b2.s_ack = 1'b1; b2.m_lock[1] = 1'b0; #1;
      check_val("lk_wr_s_access", b2.s_access, 1);
      check_val("lk_wr_grant_id", gid2, 1);
      check_val("lk_wr_s_wr_en", b2.s_wr_en, 1);
      check_val("lk_wr_s_data_out", b2.s_data_out, 16'h1234);
      check_val("lk_wr_m_ack", b2.m_ack, 2'b10);
      settle();
      b2.s_ack = 1'b0; b2.m_access[1] = 1'b0; b2.m_wr_en[1] = 1'b0; #1;
      check_val("lk_release_grant_valid", gv2, 0);
      settle(); #1;
      check_val("lk_m0_grant_valid", gv2, 1);
      check_val("lk_m0_grant_id", gid2, 0);
      check_val("lk_m0_s_addr", b2.s_addr, 32'h777);
      b2.s_ack = 1'b1; #1;
      check_val("lk_m0_m_ack", b2.m_ack, 2'b01);
      settle(); b2.s_ack = 1'b0; b2.m_access[0] = 1'b0;

      // ---------------- reset mid-transfer ----------------
      // Pointer is now 1; a reset must return it to 0.
      settle(); b2.m_access[0] = 1'b1;
      settle(); #1;
      check_val("rm_busy_s_access", b2.s_access, 1);
      rst = 1'b1; b2.s_ack = 1'b1; b2.m_access[1] = 1'b1; #1;
      check_val("rm_ack_dropped", b2.m_ack, 0);
      settle(); rst = 1'b0; b2.s_ack = 1'b0; #1;
      check_val("rm_grant_valid", gv2, 0);
      check_val("rm_m_ack", b2.m_ack, 0);
      settle(); #1;
      check_val("rm_ptr_zero_grant_id", gid2, 0);
      check_val("rm_regrant_valid", gv2, 1);
      b2.s_ack = 1'b1;
      settle(); b2.s_ack = 1'b0; b2.m_access = '0;

      // ---------------- protocol violation: request withdrawn ----------------
      settle(); b2.m_access[1] = 1'b1;
      settle(); b2.m_access[1] = 1'b0; #1;
      check_val("pv_s_access", b2.s_access, 0);
      check_val("pv_m_ack", b2.m_ack, 0);
      settle(); #1;
      check_val("pv_grant_valid", gv2, 0);

      // ---------------- round-robin fairness, 4 masters ----------------
      settle(); b4.m_access = 4'hF; b4.s_ack = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_val("rr_idle_grant_valid", gv4, 0);
         settle(); #1;
         check_val("rr_grant_id", gid4, exp_rr[k]);
         check_val("rr_m_ack", b4.m_ack, 32'(1) << exp_rr[k]);
         if (k < 4) for (int i = 0; i < 4; i++) ack_cnt[i] += int'(b4.m_ack[i]);
         settle();
      end
      for (int i = 0; i < 4; i++) check_val($sformatf("rr_ack_count_m%0d", i), ack_cnt[i], 1);
      b4.m_access = '0; b4.s_ack = 1'b0;

      // ---------------- fixed priority, masters 0 and 2 ----------------
      settle(); bf.m_access = 4'b0101; bf.s_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_val("fp_idle_grant_valid", gvf, 0);
         settle(); #1;
         check_val("fp_grant_id", gidf, 0);
         check_val("fp_m_ack", bf.m_ack, 4'b0001);
         settle();
      end
      bf.m_access = 4'b0100; #1;
      check_val("fp_idle2_grant_valid", gvf, 0);
      settle(); #1;
      check_val("fp_m2_grant_id", gidf, 2);
      check_val("fp_m2_m_ack", bf.m_ack, 4'b0100);
      settle(); bf.m_access = '0; bf.s_ack = 1'b0;

      settle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the core's word-addressed memory bus protocol: access/ack handshake, `[ADDR_WIDTH:1]` address, byte selects, write enable and io.
- Replaces the fixed split of instruction and data buses. It lets prefetch, load/store and future masters (DMA, debug) share one external memory port.
- Supports round-robin or fixed priority, plus a per-master lock for indivisible back-to-back sequences (LOCK-prefixed read-modify-write).

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8); master 0 has highest fixed priority.
- ADDR_WIDTH, 19, word address width; addresses carry bits `[ADDR_WIDTH:1]`.
- DATA_WIDTH, 16, data bus width; byte selects are DATA_WIDTH/8 bits.
- ROUND_ROBIN, 1, 1 = rotating priority, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- m_access  input  NUM_MASTERS  per-master request; held until that master's ack.
- m_lock  input  NUM_MASTERS  per-master request to keep the grant after ack.
- m_addr  input  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i occupies slice i.
- m_data_out  input  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_wr_en  input  NUM_MASTERS  write strobe qualifier.
- m_bytesel  input  NUM_MASTERS*(DATA_WIDTH/8)  byte enables.
- m_io  input  NUM_MASTERS  io-space access.
- m_ack  output  NUM_MASTERS  one-hot ack, copy of s_ack for the granted master.
- m_data_in  output  DATA_WIDTH  read data, broadcast copy of s_data_in.
- s_addr  output  ADDR_WIDTH  slave address.
- s_data_out  output  DATA_WIDTH  slave write data.
- s_access  output  1  slave request.
- s_ack  input  1  slave single-cycle completion.
- s_data_in  input  DATA_WIDTH  slave read data, valid with s_ack.
- s_wr_en  output  1  slave write enable.
- s_bytesel  output  DATA_WIDTH/8  slave byte enables.
- s_io  output  1  slave io qualifier.
- grant_valid  output  1  a master currently owns the bus.
- grant_id  output  $clog2(NUM_MASTERS) (min 1)  index of the owning master.

Behaviour:
- States:
  - IDLE: no owner.
  - BUSY: transfer outstanding.
  - LOCKED: owner retained between transfers.
- Reset values: state = IDLE, grant_valid = 0, grant_id = 0, priority pointer = 0. s_access, s_wr_en, s_io, m_ack are 0. s_addr, s_data_out, s_bytesel are 0. Reset mid-transfer aborts to IDLE on the next edge; an in-flight s_ack that cycle is dropped.
- IDLE: when any m_access is set, pick a winner:
  - ROUND_ROBIN = 1: first requester scanning upward from the pointer, wrapping at NUM_MASTERS-1 to 0.
  - ROUND_ROBIN = 0: lowest index.
  - At the edge, register grant_id, set grant_valid = 1, go to BUSY. Arbitration costs exactly 1 cycle: s_access first rises the cycle after m_access.
- BUSY outputs:
  - s_access = m_access[grant_id]. s_addr, s_data_out, s_wr_en, s_bytesel, s_io are muxed combinationally from master grant_id.
  - m_ack[grant_id] = s_ack; all other m_ack bits are 0.
- BUSY, s_ack = 1:
  - If m_lock[grant_id] is set, go to LOCKED and keep the grant.
  - Otherwise go to IDLE and clear grant_valid.
  - Pointer update (round-robin only) on every completing ack: pointer = (grant_id+1) mod NUM_MASTERS.
- BUSY, m_access[grant_id] low without ack: this is a protocol violation. Required handling: s_access follows it low, and the block returns to IDLE next edge with no ack.
- LOCKED: s_access = 0 and all slave outputs are 0.
  - If m_access[grant_id] is set, go to BUSY with no re-arbitration (zero arbitration cycle, s_access rises the next cycle).
  - Else if m_lock[grant_id] is low, go to IDLE.
  - Other masters wait for as long as the lock is held; there is no timeout.
- Outside BUSY, all slave outputs are 0.
- A new arbitration never happens in the cycle an ack completes; minimum IDLE dwell is 1 cycle, so back-to-back transfers from different masters are separated by 1 idle cycle.
- m_data_in is always s_data_in; masters qualify it with their own m_ack.
- NUM_MASTERS = 1 must elaborate: grant_id is tied to 0 and round-robin degenerates to fixed.

Test Plan:
- Single master: master 1 reads address 0x12345 with bytesel 2'b11; slave acks 3 cycles later with 0xBEEF. Expect s_access rising 1 cycle after m_access, m_ack = 2'b10 coincident with s_ack, m_data_in = 0xBEEF, then IDLE.
- Round-robin fairness, NUM_MASTERS = 4: all four request continuously and the slave acks on the 1st BUSY cycle. Expect grant order 0,1,2,3,0 and each master acked once per 4 transfers.
- Fixed priority, ROUND_ROBIN = 0: masters 0 and 2 request continuously. Expect master 0 granted every time and master 2 never granted until m_access[0] drops.
- Lock: master 1 holds m_lock and issues a read of 0x00010 then a write of 0x1234 to 0x00010 while master 0 requests. Expect both master-1 transfers before any master-0 grant. Expect s_access rising on the cycle after master 1 re-asserts m_access with no IDLE cycle, and master 0 granted 1 cycle after m_lock drops.
- Reset mid-transfer: assert reset while in BUSY with s_ack = 1 in the same cycle. Expect m_ack all 0, grant_valid = 0 next cycle, and round-robin pointer = 0.
- Write path: master 0 writes 0xA5 to byte 1 of io port 0x0040 (bytesel 2'b10, m_io = 1, m_wr_en = 1). Expect s_wr_en = 1, s_io = 1, s_bytesel = 2'b10 and s_data_out matching master 0's data for the whole BUSY interval.
